serial_lane_rx_aligner: RTL and testbench
=========================================

// Module: serial_lane_rx_aligner
// PURPOSE
//  Receive end of one serial lane: deserialises the 1-bit stream driven by the PHY transmit
//  serializer (MSB first, one bit per clk_32f) into bytes. Hunts for COM symbol boundaries
//  and declares lane sync after COM_COUNT consecutive aligned COMs. Then presents data bytes
//  with valid; COM bytes are treated as idle. Sits per lane inside the PHY receive path,
//  ahead of lane un-striping.
// PARAMETERS
//  COM_SYMBOL  8'hBC  idle/alignment symbol sent by the transmitter when valid_in is low
//  COM_COUNT   4      consecutive aligned COMs required to enter SYNC (legal range 2..15)
// PORTS
//  clk_32f      in   1  bit clock; single clock domain, all flops on rising edge
//  reset        in   1  asynchronous, active-high; clears all state immediately
//  serial_in    in   1  serial lane bit, MSB of each byte first
//  sync_en      in   1  sincronizar_bus; low forces HUNT and holds outputs idle
//  data_out     out  8  received byte; held for the full 8-cycle byte period
//  valid_out    out  1  data_out holds a non-COM byte; held with data_out
//  active       out  1  high while in SYNC
// BEHAVIOUR
//  - Reset: state=HUNT; sr=0; bit_cnt=0; com_cnt=0; data_out=0; valid_out=0; active=0.
//  - Shift register each cycle: sr <= {sr[6:0], serial_in}.
//  - Window: w = {sr[6:0], serial_in}, combinational. The byte is complete in the cycle
//    its 8th bit is present on serial_in.
//  - HUNT: bit-granular search; test w==COM_SYMBOL on every cycle.
//    Match -> COUNT; bit_cnt<=0; com_cnt<=1.
//  - COUNT: bit_cnt increments mod 8. When bit_cnt==7, the byte boundary is reached:
//      w==COM and com_cnt+1==COM_COUNT -> SYNC; active<=1.
//      w==COM otherwise -> com_cnt<=com_cnt+1.
//      w!=COM -> HUNT; com_cnt<=0.
//      A non-COM byte restarts the count, so the COMs must be consecutive.
//  - SYNC: bit_cnt keeps counting mod 8. At bit_cnt==7:
//      w==COM -> valid_out<=0, data_out unchanged.
//      w!=COM -> data_out<=w, valid_out<=1.
//    Outputs change only at byte boundaries.
//  - Latency: 8th bit on serial_in in cycle t -> data_out/valid_out visible in cycle t+1.
//  - Sync loss: SYNC is left only via sync_en low or reset. There is no symbol-error detection.
//  - sync_en low, in any state, registered next edge:
//      state=HUNT; com_cnt=0; bit_cnt=0; valid_out=0; active=0; data_out=0.
//    sr keeps shifting. While sync_en stays low, the state remains HUNT and no match is taken.
//  - sync_en rising: the hunt starts that cycle. A COM window completing in the same cycle
//    as the rise counts.
//  - Reset mid-byte or mid-SYNC: all outputs return to reset values asynchronously.
//    Realignment needs COM_COUNT fresh COMs.
//  - com_cnt width is 4 bits. bit_cnt width is 3 bits and wraps 7->0 without a flag.
// STRUCTURE
//  - Shared package/include (phy_defs.vh):
//    COM_SYMBOL value; state encodings HUNT=2'd0, COUNT=2'd1, SYNC=2'd2.
//    The PHY transmit serializer uses the same COM_SYMBOL.
//  - Single module; no sub-module needed. One FSM always block, plus a shift/counter block.
//  - Instanced once per lane (bus_serial_0, bus_serial_1) in the PHY receive wrapper.
// TESTING
//  1. Reset: reset=1 mid-stream -> data_out=0, valid_out=0, active=0 in the same cycle.
//  2. Bring-up: sync_en=1; 3 random bits then 4x 8'hBC -> active rises 1 cycle after the
//     8th bit of the 4th COM. valid_out stays 0.
//  3. Data: after SYNC send 8'hA5, 8'h3C, 8'hBC -> data_out=A5, valid=1 for 8 cycles;
//     then 3C, valid=1; then valid=0 with data_out still 3C.
//  4. Broken run: BC,BC,BC,8'h00,BC,BC,BC,BC -> no active until the 8th symbol.
//     The count restarts after 00.
//  5. Bit-slip: stream offset by 5 bits relative to cycle 0 -> HUNT aligns.
//     A5 is recovered exactly.
//  6. sync_en drop in SYNC mid-byte -> next cycle active=0, valid_out=0, data_out=0.
//     Re-raise plus 4 COMs -> resync.

Source files
------------

// File: rtl/serial_lane_rx_aligner_pkg.sv
// Shared definitions for the serial lane receive aligner.
//   PHY_COM_SYMBOL  : idle/alignment symbol, same value the transmit serializer emits
//   PHY_COM_COUNT   : default number of consecutive aligned COMs needed for lane sync
//   rx_state_t      : aligner state encoding (HUNT=0, COUNT=1, SYNC=2)
//   is_com()        : symbol compare helper
package serial_lane_rx_aligner_pkg;

  localparam logic [7:0] PHY_COM_SYMBOL = 8'hBC;
  localparam int         PHY_COM_COUNT  = 4;

  typedef enum logic [1:0] {
    ST_HUNT  = 2'd0,
    ST_COUNT = 2'd1,
    ST_SYNC  = 2'd2
  } rx_state_t;

  function automatic logic is_com(input logic [7:0] sym, input logic [7:0] com);
    return (sym == com);
  endfunction

endpackage

// File: rtl/serial_lane_rx_aligner_if.sv
// Lane-side bus of the receive aligner.
//   serial_in  : serial lane bit, MSB of each byte first
//   sync_en    : lane sync enable; low forces the aligner back to hunting
//   data_out   : received byte, held for the whole byte period
//   valid_out  : data_out holds a non-COM byte
//   active     : lane is in sync
// Modports: master drives the serial stream and enable, slave is the aligner.
interface serial_lane_rx_aligner_if;

  logic       serial_in;
  logic       sync_en;
  logic [7:0] data_out;
  logic       valid_out;
  logic       active;

  modport master (
    output serial_in,
    output sync_en,
    input  data_out,
    input  valid_out,
    input  active
  );

  modport slave (
    input  serial_in,
    input  sync_en,
    output data_out,
    output valid_out,
    output active
  );

endinterface

// File: rtl/serial_lane_rx_aligner.sv
// Serial lane receive aligner: deserialises the MSB-first bit stream into bytes, hunts for
// the COM symbol on every bit position, and declares lane sync after COM_COUNT consecutive
// byte-aligned COMs. In sync, non-COM bytes are presented with valid_out; COMs are idle.
// Ports:
//   clk_32f : bit clock, all flops on the rising edge
//   reset   : asynchronous, active-high
//   lane    : serial_lane_rx_aligner_if.slave (serial_in, sync_en -> data_out, valid_out, active)
//
// state  | meaning
// -------+-----------------------------------------------------------------
// HUNT   | bit-granular search for a COM in the sliding 8-bit window
// COUNT  | byte-aligned, counting consecutive COMs at each byte boundary
// SYNC   | lane in sync; bytes delivered at each boundary, COMs are idle
module serial_lane_rx_aligner
  import serial_lane_rx_aligner_pkg::*;
#(
  parameter logic [7:0] COM_SYMBOL = PHY_COM_SYMBOL,
  parameter int         COM_COUNT  = PHY_COM_COUNT
) (
  input  logic                     clk_32f,
  input  logic                     reset,
  serial_lane_rx_aligner_if.slave  lane
);

  rx_state_t  state;
  logic [6:0] sr;
  logic [2:0] bit_cnt;
  logic [3:0] com_cnt;
  logic [3:0] com_cnt_inc;
  logic [7:0] win;
  logic       win_com;
  logic       byte_end;
  logic [7:0] data_q;
  logic       valid_q;
  logic       active_q;

  // Only seven history bits are kept: the eighth bit of the window is the live serial_in,
  // so a byte is complete in the same cycle its last bit arrives.
  assign win         = {sr, lane.serial_in};
  assign win_com     = is_com(win, COM_SYMBOL);
  assign byte_end    = (bit_cnt == 3'd7);
  assign com_cnt_inc = com_cnt + 4'd1;

  // Shift register runs regardless of sync_en. bit_cnt is parked at 0 while hunting so the
  // first cycle after a COM match is bit 0 of the next byte.
  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      sr      <= '0;
      bit_cnt <= '0;
    end else begin
      sr <= {sr[5:0], lane.serial_in};
      if (!lane.sync_en || state == ST_HUNT) begin
        bit_cnt <= '0;
      end else begin
        bit_cnt <= bit_cnt + 3'd1;
      end
    end
  end

  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      state    <= ST_HUNT;
      com_cnt  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      active_q <= 1'b0;
    end else if (!lane.sync_en) begin
      state    <= ST_HUNT;
      com_cnt  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      active_q <= 1'b0;
    end else begin
      case (state)
        ST_HUNT: begin
          if (win_com) begin
            state   <= ST_COUNT;
            com_cnt <= 4'd1;
          end
        end
        ST_COUNT: begin
          if (byte_end) begin
            if (win_com) begin
              com_cnt <= com_cnt_inc;
              if (com_cnt_inc == 4'(COM_COUNT)) begin
                state    <= ST_SYNC;
                active_q <= 1'b1;
              end
            end else begin
              // a non-COM byte breaks the run; the COMs must be consecutive
              state   <= ST_HUNT;
              com_cnt <= '0;
            end
          end
        end
        ST_SYNC: begin
          if (byte_end) begin
            if (win_com) begin
              valid_q <= 1'b0;
            end else begin
              data_q  <= win;
              valid_q <= 1'b1;
            end
          end
        end
        default: begin
          state   <= ST_HUNT;
          com_cnt <= '0;
        end
      endcase
    end
  end

  assign lane.data_out  = data_q;
  assign lane.valid_out = valid_q;
  assign lane.active    = active_q;

endmodule

// File: tb/tb_serial_lane_rx_aligner.sv
module tb_serial_lane_rx_aligner;
  import serial_lane_rx_aligner_pkg::*;

  logic clk_32f = 1'b0;
  logic reset   = 1'b1;

  serial_lane_rx_aligner_if lane ();

  serial_lane_rx_aligner dut (
    .clk_32f (clk_32f),
    .reset   (reset),
    .lane    (lane.slave)
  );

  always #5 clk_32f = ~clk_32f;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: bit history plus the cycle at which byte alignment was found.
  // Byte boundaries are every 8th cycle after that anchor.
  bit         hist[$];
  int         t_now;
  int         anchor;
  bit         hunting;
  int         run;
  logic [7:0] e_data;
  bit         e_valid;
  bit         e_active;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model_window();
    logic [7:0] w = '0;
    for (int i = 0; i < 8; i++) begin
      int idx = hist.size() - 8 + i;
      w = {w[6:0], (idx >= 0) ? hist[idx] : 1'b0};
    end
    return w;
  endfunction

  task automatic model_clear();
    hist.delete();
    t_now    = 0;
    anchor   = 0;
    hunting  = 1'b1;
    run      = 0;
    e_data   = '0;
    e_valid  = 1'b0;
    e_active = 1'b0;
  endtask

  task automatic model_step(input bit b, input bit en);
    logic [7:0] w;
    hist.push_back(b);
    if (hist.size() > 8) void'(hist.pop_front());
    t_now++;
    w = model_window();
    if (!en) begin
      hunting  = 1'b1;
      run      = 0;
      e_data   = '0;
      e_valid  = 1'b0;
      e_active = 1'b0;
    end else if (hunting) begin
      if (w == PHY_COM_SYMBOL) begin
        hunting = 1'b0;
        anchor  = t_now;
        run     = 1;
      end
    end else if ((t_now - anchor) % 8 == 0) begin
      if (!e_active) begin
        if (w == PHY_COM_SYMBOL) begin
          run++;
          if (run == PHY_COM_COUNT) e_active = 1'b1;
        end else begin
          hunting = 1'b1;
          run     = 0;
        end
      end else if (w == PHY_COM_SYMBOL) begin
        e_valid = 1'b0;
      end else begin
        e_data  = w;
        e_valid = 1'b1;
      end
    end
  endtask

  // Drive one bit, advance one clock, compare all outputs against the model.
  task automatic tick(input bit b, input bit en);
    lane.serial_in = b;
    lane.sync_en   = en;
    model_step(b, en);
    @(posedge clk_32f);
    #1;
    check("data_out",  lane.data_out,        e_data);
    check("valid_out", 8'(lane.valid_out),   8'(e_valid));
    check("active",    8'(lane.active),      8'(e_active));
  endtask

  task automatic send_byte(input logic [7:0] v, input bit en);
    for (int i = 7; i >= 0; i--) tick(v[i], en);
  endtask

  task automatic send_rand_bits(input int n);
    for (int i = 0; i < n; i++) tick(1'($urandom_range(0, 1)), 1'b1);
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    check("rst_data",   lane.data_out,       8'h00);
    check("rst_valid",  8'(lane.valid_out),  8'h00);
    check("rst_active", 8'(lane.active),     8'h00);
    @(posedge clk_32f);
    #1 reset = 1'b0;
    model_clear();
  endtask

  initial begin
    logic [7:0] r;
    lane.serial_in = 1'b0;
    lane.sync_en   = 1'b0;
    model_clear();
    repeat (3) @(posedge clk_32f);
    #1;
    check("init_data",   lane.data_out,      8'h00);
    check("init_valid",  8'(lane.valid_out), 8'h00);
    check("init_active", 8'(lane.active),    8'h00);
    reset = 1'b0;

    // bring-up: 3 random bits then 4 COMs
    send_rand_bits(3);
    for (int k = 0; k < 3; k++) begin
      send_byte(PHY_COM_SYMBOL, 1'b1);
      check("bringup_early", 8'(lane.active), 8'h00);
    end
    send_byte(PHY_COM_SYMBOL, 1'b1);
    check("bringup_active", 8'(lane.active),    8'h01);
    check("bringup_valid",  8'(lane.valid_out), 8'h00);

    // data A5, 3C, then idle COM
    send_byte(8'hA5, 1'b1);
    check("a5_data", lane.data_out, 8'hA5);
    check("a5_valid", 8'(lane.valid_out), 8'h01);
    send_byte(8'h3C, 1'b1);
    check("3c_data", lane.data_out, 8'h3C);
    send_byte(PHY_COM_SYMBOL, 1'b1);
    check("idle_valid", 8'(lane.valid_out), 8'h00);
    check("idle_data",  lane.data_out,      8'h3C);

    // random traffic with interspersed COMs
    for (int k = 0; k < 24; k++) begin
      r = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) r = PHY_COM_SYMBOL;
      send_byte(r, 1'b1);
    end

    // sync_en drop mid-byte
    send_rand_bits(3);
    tick(1'b1, 1'b0);
    check("drop_active", 8'(lane.active),    8'h00);
    check("drop_valid",  8'(lane.valid_out), 8'h00);
    check("drop_data",   lane.data_out,      8'h00);
    for (int k = 0; k < 2; k++) send_byte(PHY_COM_SYMBOL, 1'b0);
    check("low_no_sync", 8'(lane.active), 8'h00);
    for (int k = 0; k < 4; k++) send_byte(PHY_COM_SYMBOL, 1'b1);
    check("resync_active", 8'(lane.active), 8'h01);

    // broken COM run restarts the count
    tick(1'b0, 1'b0);
    for (int k = 0; k < 3; k++) send_byte(PHY_COM_SYMBOL, 1'b1);
    send_byte(8'h00, 1'b1);
    for (int k = 0; k < 3; k++) begin
      send_byte(PHY_COM_SYMBOL, 1'b1);
      check("broken_early", 8'(lane.active), 8'h00);
    end
    send_byte(PHY_COM_SYMBOL, 1'b1);
    check("broken_active", 8'(lane.active), 8'h01);

    // reset mid-SYNC: outputs clear asynchronously
    send_rand_bits(4);
    do_reset();

    // bit slip: 5-bit offset, alignment found and A5 recovered
    send_rand_bits(5);
    for (int k = 0; k < 4; k++) send_byte(PHY_COM_SYMBOL, 1'b1);
    check("slip_active", 8'(lane.active), 8'h01);
    send_byte(8'hA5, 1'b1);
    check("slip_data",  lane.data_out,      8'hA5);
    check("slip_valid", 8'(lane.valid_out), 8'h01);

    // sync_en rising in the very cycle a COM completes: that COM counts
    tick(1'b0, 1'b0);
    r = PHY_COM_SYMBOL;
    for (int i = 7; i >= 1; i--) tick(r[i], 1'b0);
    tick(r[0], 1'b1);
    for (int k = 0; k < 2; k++) send_byte(PHY_COM_SYMBOL, 1'b1);
    check("rise_early", 8'(lane.active), 8'h00);
    send_byte(PHY_COM_SYMBOL, 1'b1);
    check("rise_active", 8'(lane.active), 8'h01);
    for (int k = 0; k < 8; k++) send_byte(8'($urandom_range(0, 255)), 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
